bypass_scoreboard: RTL and testbench

- Parametrised operand bypass and hazard unit for the decode/issue stage. It is the successor to the fixed two-stage bypass controller.
- Forwards from NUM_FWD_STAGES pipeline stages plus the long-latency writeback port, selected in priority order.
- Keeps a per-register busy scoreboard for multi-cycle ops (mul/div/long loads) that leave the normal pipeline.
- Raises stall on RAW and WAW hazards that cannot be forwarded.

---
 rtl/bypass_scoreboard_pkg.sv | 21 ++
 rtl/bypass_operand_select.sv | 52 +++++
 rtl/bypass_scoreboard.sv | 130 +++++++++++++
 tb/tb_bypass_scoreboard.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bypass_scoreboard_pkg.sv
// Shared types and constants for the operand bypass / hazard unit.
// fwd_src_t fields use fixed maximum widths so the struct can cross module boundaries.
package bypass_scoreboard_pkg;

  localparam int NUM_FWD_STAGES_DEFAULT = 2;
  localparam int ZERO_REG               = 0;
  localparam int FWD_ADDR_W             = 8;
  localparam int FWD_DATA_W             = 64;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [FWD_ADDR_W-1:0] rd_addr;
    logic [FWD_DATA_W-1:0] data;
  } fwd_src_t;

  function automatic logic is_zero_reg(input logic [FWD_ADDR_W-1:0] addr);
    return addr == FWD_ADDR_W'(ZERO_REG);
  endfunction

endpackage

// File: rtl/bypass_operand_select.sv
// Combinational operand resolution for one source register: forwarding stages in
// age order, then the long-latency writeback port, then the busy scoreboard.
module bypass_operand_select
  import bypass_scoreboard_pkg::*;
#(
  parameter int NUM_FWD_STAGES = NUM_FWD_STAGES_DEFAULT,
  parameter int ADDR_W         = 5
) (
  input  logic                                used,
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [FWD_DATA_W-1:0]               rf_data,
  input  fwd_src_t [NUM_FWD_STAGES-1:0]       fwd,
  input  logic                                wb_valid,
  input  logic [ADDR_W-1:0]                   wb_rd_addr,
  input  logic [FWD_DATA_W-1:0]               wb_data,
  input  logic                                busy,
  output logic [FWD_DATA_W-1:0]               data,
  output logic                                hazard
);

  logic [FWD_ADDR_W-1:0] addr_ext;
  logic                  matched;

  assign addr_ext = FWD_ADDR_W'(addr);

  always_comb begin
    data    = rf_data;
    hazard  = 1'b0;
    matched = 1'b0;
    if (used && !is_zero_reg(addr_ext)) begin
      // Youngest matching stage owns the register, even if its result is not ready yet.
      for (int i = 0; i < NUM_FWD_STAGES; i++) begin
        if (!matched && fwd[i].valid && fwd[i].rd_addr == addr_ext) begin
          matched = 1'b1;
          if (fwd[i].ready) begin
            data = fwd[i].data;
          end else begin
            hazard = 1'b1;
          end
        end
      end
      if (!matched) begin
        if (wb_valid && wb_rd_addr == addr) begin
          data = wb_data;
        end else if (busy) begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// Operand bypass, busy scoreboard and RAW/WAW stall generation for the issue stage.
// Optional stall counters are built when BYPASS_SCOREBOARD_PERF_EN is defined.
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int NUM_FWD_STAGES = NUM_FWD_STAGES_DEFAULT,
  parameter int NUM_REGS       = 32,
  parameter int ADDR_W         = $clog2(NUM_REGS),
  parameter int DATA_W         = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issueValid,
  input  logic [ADDR_W-1:0]                  rs1Addr,
  input  logic [ADDR_W-1:0]                  rs2Addr,
  input  logic                               rs1Used,
  input  logic                               rs2Used,
  input  logic [DATA_W-1:0]                  rs1Data,
  input  logic [DATA_W-1:0]                  rs2Data,
  input  logic [NUM_FWD_STAGES-1:0]          fwdValid,
  input  logic [NUM_FWD_STAGES-1:0]          fwdReady,
  input  logic [NUM_FWD_STAGES*ADDR_W-1:0]   fwdRdAddr,
  input  logic [NUM_FWD_STAGES*DATA_W-1:0]   fwdData,
  input  logic [ADDR_W-1:0]                  issueRdAddr,
  input  logic                               issueLongLat,
  input  logic                               wbValid,
  input  logic [ADDR_W-1:0]                  wbRdAddr,
  input  logic [DATA_W-1:0]                  wbData,
  output logic                               stall,
  output logic [DATA_W-1:0]                  bypassedRs1,
  output logic [DATA_W-1:0]                  bypassedRs2,
  output logic [NUM_REGS-1:0]                busyVec
`ifdef BYPASS_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                        rawStallCnt,
  output logic [31:0]                        wawStallCnt
`endif
);

  logic [NUM_REGS-1:0]             busy_reg;
  logic [NUM_REGS-1:0]             busy_next;
  logic [NUM_REGS-1:0]             busy_eff;
  fwd_src_t [NUM_FWD_STAGES-1:0]   fwd_src;
  logic [FWD_DATA_W-1:0]           rs1_sel_data;
  logic [FWD_DATA_W-1:0]           rs2_sel_data;
  logic                            rs1_hazard;
  logic                            rs2_hazard;
  logic                            raw_hazard;
  logic                            waw_hazard;
  logic                            issue_set;
  logic                            unused_sel_bits;

  for (genvar gi = 0; gi < NUM_FWD_STAGES; gi++) begin : g_fwd
    assign fwd_src[gi] = '{valid:   fwdValid[gi],
                           ready:   fwdReady[gi],
                           rd_addr: FWD_ADDR_W'(fwdRdAddr[gi*ADDR_W +: ADDR_W]),
                           data:    FWD_DATA_W'(fwdData[gi*DATA_W +: DATA_W])};
  end

  // While reset is asserted the pending entries are already being discarded.
  assign busy_eff = rst ? '0 : busy_reg;

  bypass_operand_select #(.NUM_FWD_STAGES(NUM_FWD_STAGES), .ADDR_W(ADDR_W)) u_rs1_sel (
    .used(rs1Used), .addr(rs1Addr), .rf_data(FWD_DATA_W'(rs1Data)), .fwd(fwd_src),
    .wb_valid(wbValid), .wb_rd_addr(wbRdAddr), .wb_data(FWD_DATA_W'(wbData)),
    .busy(busy_eff[rs1Addr]), .data(rs1_sel_data), .hazard(rs1_hazard)
  );

  bypass_operand_select #(.NUM_FWD_STAGES(NUM_FWD_STAGES), .ADDR_W(ADDR_W)) u_rs2_sel (
    .used(rs2Used), .addr(rs2Addr), .rf_data(FWD_DATA_W'(rs2Data)), .fwd(fwd_src),
    .wb_valid(wbValid), .wb_rd_addr(wbRdAddr), .wb_data(FWD_DATA_W'(wbData)),
    .busy(busy_eff[rs2Addr]), .data(rs2_sel_data), .hazard(rs2_hazard)
  );

  // Only the low DATA_W bits carry the operand; the rest are zero extension.
  assign bypassedRs1     = rs1_sel_data[DATA_W-1:0];
  assign bypassedRs2     = rs2_sel_data[DATA_W-1:0];
  assign unused_sel_bits = ^{rs1_sel_data, rs2_sel_data};

  assign raw_hazard = rs1_hazard || rs2_hazard;
  assign waw_hazard = issueValid && issueLongLat && issueRdAddr != ADDR_W'(ZERO_REG)
                      && busy_eff[issueRdAddr] && !(wbValid && wbRdAddr == issueRdAddr);
  assign stall      = issueValid && (raw_hazard || waw_hazard);
  assign issue_set  = issueValid && !stall && issueLongLat && issueRdAddr != ADDR_W'(ZERO_REG);

  // Set term is OR-ed last so a same-cycle writeback cannot clear a fresh allocation.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    if (gi == ZERO_REG) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_reg
      assign busy_next[gi] = (issue_set && issueRdAddr == ADDR_W'(gi))
                             || (busy_reg[gi] && !(wbValid && wbRdAddr == ADDR_W'(gi)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busyVec = busy_reg;

`ifdef BYPASS_SCOREBOARD_PERF_EN
  logic [31:0] raw_cnt_reg;
  logic [31:0] waw_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_cnt_reg <= '0;
      waw_cnt_reg <= '0;
    end else begin
      if (issueValid && raw_hazard && raw_cnt_reg != '1) begin
        raw_cnt_reg <= raw_cnt_reg + 32'd1;
      end
      if (waw_hazard && waw_cnt_reg != '1) begin
        waw_cnt_reg <= waw_cnt_reg + 32'd1;
      end
    end
  end

  assign rawStallCnt = raw_cnt_reg;
  assign wawStallCnt = waw_cnt_reg;
`else
  // Stall counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard: a table of combinational forwarding cases,
// followed by hand-written scoreboard, WAW, zero-register and reset sequences.
module tb_bypass_scoreboard;

  localparam logic [31:0] RF1 = 32'hAAAA_0001;
  localparam logic [31:0] RF2 = 32'hBBBB_0002;

  logic        clk;
  logic        rst;
  logic        issueValid;
  logic [4:0]  rs1Addr, rs2Addr;
  logic        rs1Used, rs2Used;
  logic [31:0] rs1Data, rs2Data;
  logic [1:0]  fwdValid, fwdReady;
  logic [9:0]  fwdRdAddr;
  logic [63:0] fwdData;
  logic [4:0]  issueRdAddr;
  logic        issueLongLat;
  logic        wbValid;
  logic [4:0]  wbRdAddr;
  logic [31:0] wbData;
  logic        stall;
  logic [31:0] bypassedRs1, bypassedRs2;
  logic [31:0] busyVec;
`ifdef BYPASS_SCOREBOARD_PERF_EN
  logic [31:0] rawStallCnt, wawStallCnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bypass_scoreboard dut (
    .clk(clk), .rst(rst), .issueValid(issueValid),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Used(rs1Used), .rs2Used(rs2Used),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .fwdValid(fwdValid), .fwdReady(fwdReady), .fwdRdAddr(fwdRdAddr), .fwdData(fwdData),
    .issueRdAddr(issueRdAddr), .issueLongLat(issueLongLat),
    .wbValid(wbValid), .wbRdAddr(wbRdAddr), .wbData(wbData),
    .stall(stall), .bypassedRs1(bypassedRs1), .bypassedRs2(bypassedRs2), .busyVec(busyVec)
`ifdef BYPASS_SCOREBOARD_PERF_EN
    , .rawStallCnt(rawStallCnt), .wawStallCnt(wawStallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [1:0]  fv;
    logic [1:0]  fr;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        es;
    logic        c1;
    logic [31:0] e1;
    logic        c2;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic idle();
    issueValid   = 1'b0;
    rs1Addr      = 5'd0;
    rs2Addr      = 5'd0;
    rs1Used      = 1'b0;
    rs2Used      = 1'b0;
    rs1Data      = RF1;
    rs2Data      = RF2;
    fwdValid     = 2'b00;
    fwdReady     = 2'b00;
    fwdRdAddr    = 10'd0;
    fwdData      = 64'd0;
    issueRdAddr  = 5'd0;
    issueLongLat = 1'b0;
    wbValid      = 1'b0;
    wbRdAddr     = 5'd0;
    wbData       = 32'd0;
  endtask

  task automatic apply(input vec_t v);
    idle();
    issueValid = v.iv;
    rs1Addr    = v.rs1;
    rs1Used    = v.u1;
    rs2Addr    = v.rs2;
    rs2Used    = v.u2;
    fwdValid   = v.fv;
    fwdReady   = v.fr;
    fwdRdAddr  = {v.rd1, v.rd0};
    fwdData    = {v.d1, v.d0};
    wbValid    = v.wv;
    wbRdAddr   = v.wrd;
    wbData     = v.wd;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle();
    issueValid   = 1'b1;
    issueLongLat = 1'b1;
    issueRdAddr  = rd;
  endtask

  initial begin
    // iv rs1 u1 rs2 u2 fv fr rd0 rd1 d0 d1 wv wrd wd | stall c1 e1 c2 e2
    vecs[0]  = '{1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 2'b11, 2'b11, 5'd5, 5'd5, 32'hDEAD, 32'h1111,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 1'b1, RF2};
    vecs[1]  = '{1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 2'b11, 2'b11, 5'd8, 5'd5, 32'h2222, 32'h1111,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1111, 1'b1, RF2};
    vecs[2]  = '{1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 2'b01, 2'b00, 5'd7, 5'd0, 32'h3333, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, RF1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 5'd1, 1'b0, 5'd7, 1'b1, 2'b01, 2'b00, 5'd7, 5'd0, 32'h3333, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, RF1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 2'b01, 2'b01, 5'd7, 5'd0, 32'h3333, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, RF1, 1'b1, 32'h3333};
    vecs[5]  = '{1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 2'b01, 2'b00, 5'd7, 5'd0, 32'h3333, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, RF1, 1'b1, RF2};
    vecs[6]  = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'b01, 2'b01, 5'd0, 5'd0, 32'h5, 32'h0,
                 1'b1, 5'd0, 32'h9, 1'b0, 1'b1, RF1, 1'b1, RF2};
    vecs[7]  = '{1'b1, 5'd10, 1'b1, 5'd6, 1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                 1'b1, 5'd10, 32'h42, 1'b0, 1'b1, 32'h42, 1'b1, RF2};
    vecs[8]  = '{1'b1, 5'd10, 1'b1, 5'd6, 1'b1, 2'b10, 2'b10, 5'd0, 5'd10, 32'h0, 32'hBEEF,
                 1'b1, 5'd10, 32'h42, 1'b0, 1'b1, 32'hBEEF, 1'b1, RF2};
    vecs[9]  = '{1'b1, 5'd10, 1'b1, 5'd6, 1'b1, 2'b10, 2'b00, 5'd0, 5'd10, 32'h0, 32'hBEEF,
                 1'b1, 5'd10, 32'h42, 1'b1, 1'b0, 32'h0, 1'b1, RF2};
    vecs[10] = '{1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 2'b11, 2'b01, 5'd5, 5'd5, 32'hAAAA, 32'h1111,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hAAAA, 1'b1, RF2};
    vecs[11] = '{1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 2'b11, 2'b10, 5'd5, 5'd5, 32'hAAAA, 32'h1111,
                 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, RF2};
    vecs[12] = '{1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 2'b01, 2'b01, 5'd5, 5'd0, 32'hCAFE, 32'h0,
                 1'b1, 5'd6, 32'h77, 1'b0, 1'b1, 32'hCAFE, 1'b1, 32'h77};

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset_busy", busyVec, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #2;
      check($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].es});
      if (vecs[i].c1) check($sformatf("v%0d_rs1", i), bypassedRs1, vecs[i].e1);
      if (vecs[i].c2) check($sformatf("v%0d_rs2", i), bypassedRs2, vecs[i].e2);
    end

    // Scoreboard RAW on a long-latency destination
    @(negedge clk); issue_long(5'd9); #2;
    check("sb_issue9_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); idle(); issueValid = 1'b1; rs1Addr = 5'd9; rs1Used = 1'b1; #2;
    check("sb_busy9", busyVec, 32'h0000_0200);
    check("sb_raw9_stall", {31'b0, stall}, 32'h1);
    @(negedge clk); #2;
    check("sb_raw9_hold", {31'b0, stall}, 32'h1);
    @(negedge clk); issueValid = 1'b0; #2;
    check("sb_raw9_noissue", {31'b0, stall}, 32'h0);
    @(negedge clk); issueValid = 1'b1; wbValid = 1'b1; wbRdAddr = 5'd9; wbData = 32'h42; #2;
    check("sb_wb9_stall", {31'b0, stall}, 32'h0);
    check("sb_wb9_data", bypassedRs1, 32'h42);
    @(negedge clk); idle(); #2;
    check("sb_busy9_clear", busyVec, 32'h0);

    // WAW against an outstanding long op, and set-wins on a same-cycle writeback
    @(negedge clk); issue_long(5'd3); #2;
    check("waw_first_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); #2;
    check("waw_busy3", busyVec, 32'h0000_0008);
    check("waw_stall", {31'b0, stall}, 32'h1);
    @(negedge clk); wbValid = 1'b1; wbRdAddr = 5'd3; #2;
    check("waw_wb_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); idle(); #2;
    check("waw_set_wins", busyVec, 32'h0000_0008);
    @(negedge clk); wbValid = 1'b1; wbRdAddr = 5'd3; #2;
    @(negedge clk); idle(); #2;
    check("waw_busy3_clear", busyVec, 32'h0);

    // Zero register is never tracked
    @(negedge clk); issue_long(5'd0); #2;
    check("zero_issue_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); idle(); #2;
    check("zero_busy", busyVec, 32'h0);

    // Reset with pending entries; a stray writeback to an idle register is ignored
    @(negedge clk); issue_long(5'd4);
    @(negedge clk); issue_long(5'd12);
    @(negedge clk); idle(); wbValid = 1'b1; wbRdAddr = 5'd6; wbData = 32'h66; #2;
    check("rst_busy_4_12", busyVec, 32'h0000_1010);
    @(negedge clk); idle(); #2;
    check("wb_idle_ignored", busyVec, 32'h0000_1010);
    @(negedge clk); rst = 1'b1; issueValid = 1'b1; rs1Addr = 5'd4; rs1Used = 1'b1; #2;
    check("rst_active_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); rst = 1'b0; #2;
    check("rst_busy_clear", busyVec, 32'h0);
    check("rst_read4_stall", {31'b0, stall}, 32'h0);
    check("rst_read4_data", bypassedRs1, RF1);
`ifdef BYPASS_SCOREBOARD_PERF_EN
    check("rst_raw_cnt", rawStallCnt, 32'h0);
    check("rst_waw_cnt", wawStallCnt, 32'h0);
`endif

    @(negedge clk); idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
